// File: rtl/vmicro16_apb_pkg.sv
// ============================================================================
// Module      : vmicro16_apb_pkg
// Description : Shared definitions for the vmicro16 APB interconnect.
//               - FSM state encoding (IDLE / SETUP / ACCESS)
//               - default SoC slave base/mask tables and slave indices
// Config      : none (APB_INTERCON_PSLVERR_EN is consumed by apb_intercon_rr)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vmicro16_apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    // Slave slot indices of the default SoC map
    localparam int SLV_REGS  = 0;
    localparam int SLV_GPIO0 = 1;
    localparam int SLV_GPIO1 = 2;
    localparam int SLV_GPIO2 = 3;
    localparam int SLV_UART0 = 4;
    localparam int SLV_BRAM0 = 5;

    localparam int SOC_SLAVE_PORTS = 6;
    localparam int SOC_BUS_WIDTH   = 16;

    // Slot i lives at bits [i*16 +: 16]; slot 0 is the rightmost field
    localparam logic [SOC_SLAVE_PORTS*SOC_BUS_WIDTH-1:0] SOC_SLAVE_BASE = {
        16'h00C0,   // BRAM0
        16'h00B0,   // UART0
        16'h00A2,   // GPIO2
        16'h00A1,   // GPIO1
        16'h00A0,   // GPIO0
        16'h0080    // REGS
    };

    localparam logic [SOC_SLAVE_PORTS*SOC_BUS_WIDTH-1:0] SOC_SLAVE_MASK = {
        16'hFFC0,   // BRAM0
        16'hFFFE,   // UART0
        16'hFFFF,   // GPIO2
        16'hFFFF,   // GPIO1
        16'hFFFF,   // GPIO0
        16'hFFF0    // REGS
    };

endpackage

`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
// ============================================================================
// Module      : apb_rr_arbiter
// Description : Combinational round-robin pick. The first asserted request
//               at or above ptr_i (wrapping around) wins.
// Ports       : req_i   [N-1:0]  request vector
//               ptr_i   [IW-1:0] highest-priority index this round
//               gnt_o   [IW-1:0] winning index (0 when no request)
//               valid_o          at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] gnt_o,
    output logic          valid_o
);

    int   idx;
    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_i[idx]) begin
                found = 1'b1;
                gnt_o = idx[IW-1:0];
            end
        end
        valid_o = found;
    end

endmodule

`default_nettype wire

// File: rtl/apb_intercon_rr.sv
// ============================================================================
// Module      : apb_intercon_rr
// Description : Multi-master APB interconnect with a registered round-robin
//               arbiter. A grant is held from SETUP until the transfer
//               completes; slave windows are decoded from parameter tables
//               and unmapped addresses are completed locally.
// Config      : APB_INTERCON_PSLVERR_EN - when defined, unmapped accesses
//               return S_PSLVERR=1; otherwise S_PSLVERR is tied to 0.
// Ports       : clk, reset (async, active-low)
//               S_*  per-master APB slave-side ports (packed by master)
//               M_*  shared APB master-side ports toward peripherals
//               M_PSELx one-hot slave select, M_PRDATA/M_PREADY muxed
//               externally from the selected slave
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_intercon_rr #(
    parameter int BUS_WIDTH    = 16,
    parameter int MASTER_PORTS = 4,
    parameter int SLAVE_PORTS  = 6,
    parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_MASK = '0
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
    input  logic [MASTER_PORTS-1:0]           S_PWRITE,
    input  logic [MASTER_PORTS-1:0]           S_PSELx,
    input  logic [MASTER_PORTS-1:0]           S_PENABLE,
    input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
    output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
    output logic [MASTER_PORTS-1:0]           S_PREADY,
    output logic [MASTER_PORTS-1:0]           S_PSLVERR,

    output logic [BUS_WIDTH-1:0]              M_PADDR,
    output logic                              M_PWRITE,
    output logic [SLAVE_PORTS-1:0]            M_PSELx,
    output logic                              M_PENABLE,
    output logic [BUS_WIDTH-1:0]              M_PWDATA,
    input  logic [BUS_WIDTH-1:0]              M_PRDATA,
    input  logic                              M_PREADY
);

    import vmicro16_apb_pkg::*;

    localparam int GW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;

    apb_state_e             state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          ptr_q,   ptr_d;
    logic [SLAVE_PORTS-1:0] hit_q,   hit_d;

    logic [GW-1:0]          arb_gnt;
    logic                   arb_valid;
    logic [BUS_WIDTH-1:0]   pick_addr;
    logic [SLAVE_PORTS-1:0] pick_hit;
    logic                   hit_found;

    logic [BUS_WIDTH-1:0]   gnt_addr;
    logic [BUS_WIDTH-1:0]   gnt_wdata;
    logic                   gnt_write;
    logic                   active;
    logic                   in_access;
    logic                   mapped;
    logic                   done;

    // The master-side PENABLE carries no information the FSM needs: the
    // interconnect generates its own SETUP/ACCESS sequencing downstream.
    logic                   unused_penable;
    assign unused_penable = ^S_PENABLE;

    // ------------------------------------------------------------------
    // Arbitration and decode of the candidate winner
    // ------------------------------------------------------------------
    apb_rr_arbiter #(
        .N  (MASTER_PORTS),
        .IW (GW)
    ) u_arb (
        .req_i   (S_PSELx),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .valid_o (arb_valid)
    );

    assign pick_addr = S_PADDR[int'(arb_gnt)*BUS_WIDTH +: BUS_WIDTH];

    // Lowest-index hit wins so overlapping windows resolve deterministically
    always_comb begin
        pick_hit  = '0;
        hit_found = 1'b0;
        for (int i = 0; i < SLAVE_PORTS; i++) begin
            if (!hit_found &&
                ((pick_addr & SLAVE_MASK[i*BUS_WIDTH +: BUS_WIDTH]) ==
                 SLAVE_BASE[i*BUS_WIDTH +: BUS_WIDTH])) begin
                pick_hit[i] = 1'b1;
                hit_found   = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign active    = (state_q != APB_IDLE);
    assign in_access = (state_q == APB_ACCESS);
    assign mapped    = |hit_q;
    // Unmapped transfers have no slave to wait on and finish in one ACCESS
    assign done      = mapped ? M_PREADY : 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= APB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        hit_d   = hit_q;
        case (state_q)
            APB_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_gnt;
                    hit_d   = pick_hit;
                    state_d = APB_SETUP;
                end
            end
            APB_SETUP: begin
                state_d = APB_ACCESS;
            end
            APB_ACCESS: begin
                if (done) begin
                    state_d = APB_IDLE;
                    ptr_d   = (grant_q == GW'(MASTER_PORTS - 1)) ? '0
                                                                 : grant_q + 1'b1;
                end
            end
            default: begin
                state_d = APB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shared slave-side bus
    // ------------------------------------------------------------------
    assign gnt_addr  = S_PADDR [int'(grant_q)*BUS_WIDTH +: BUS_WIDTH];
    assign gnt_wdata = S_PWDATA[int'(grant_q)*BUS_WIDTH +: BUS_WIDTH];
    assign gnt_write = S_PWRITE[grant_q];

    assign M_PSELx   = active ? hit_q     : '0;
    assign M_PENABLE = in_access;
    assign M_PADDR   = active ? gnt_addr  : '0;
    assign M_PWDATA  = active ? gnt_wdata : '0;
    assign M_PWRITE  = active & gnt_write;

    // ------------------------------------------------------------------
    // Combinational return path to the granted master. If the master has
    // already dropped its select, the slave transfer still runs to the end
    // but nothing is reported back.
    // ------------------------------------------------------------------
    always_comb begin
        S_PREADY  = '0;
        S_PSLVERR = '0;
        S_PRDATA  = '0;
        if (in_access && S_PSELx[grant_q]) begin
            S_PREADY[grant_q] = done;
            if (mapped) begin
                S_PRDATA[int'(grant_q)*BUS_WIDTH +: BUS_WIDTH] = M_PRDATA;
            end
`ifdef APB_INTERCON_PSLVERR_EN
            S_PSLVERR[grant_q] = ~mapped;
`endif
        end
    end

endmodule

`default_nettype wire

// File: doc/apb_intercon_rr.md
# apb_intercon_rr

Parametrised multi-master APB interconnect between the vmicro16 cores and the shared peripheral bus (GPIO, UART, REGS, BRAM). It replaces the combinational priority multiplexer with a registered round-robin arbiter. The arbiter holds a grant from the SETUP phase through PREADY, and it generates clean APB SETUP/ACCESS phases toward the slaves. Slave address windows are decoded from parameter tables, and unmapped addresses are answered locally.

## Interface
- BUS_WIDTH, 16, address/data width
- MASTER_PORTS, 4, number of requesting cores (1..16)
- SLAVE_PORTS, 6, number of decoded slaves (1..16)
- SLAVE_BASE, 0, packed SLAVE_PORTS*BUS_WIDTH; slot i is the base address of slave i
- SLAVE_MASK, 0, packed SLAVE_PORTS*BUS_WIDTH; slave i hits when (addr & mask_i) == base_i
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- S_PADDR  in  MASTER_PORTS*BUS_WIDTH  per-master address
- S_PWRITE, S_PSELx, S_PENABLE  in  MASTER_PORTS  per-master APB controls
- S_PWDATA  in  MASTER_PORTS*BUS_WIDTH  per-master write data
- S_PRDATA  out  MASTER_PORTS*BUS_WIDTH  read data; zero on non-granted slots
- S_PREADY, S_PSLVERR  out  MASTER_PORTS  completion and error; only the granted bit can be high
- M_PADDR, M_PWDATA  out  BUS_WIDTH  shared toward slaves
- M_PWRITE, M_PENABLE  out  1  shared
- M_PSELx  out  SLAVE_PORTS  one-hot slave select
- M_PRDATA  in  BUS_WIDTH; M_PREADY  in  1  from the selected slave (muxed externally)

## Operation
- Request: S_PSELx[i]=1. The master holds addr/write/wdata stable until it sees S_PREADY[i].
- FSM states:
  - IDLE: when any request is present, latch grant g and go to SETUP.
  - SETUP: go to ACCESS unconditionally.
  - ACCESS: stay while M_PREADY=0. When M_PREADY=1, go to IDLE and set ptr <= g+1 (mod MASTER_PORTS).
- Arbitration: round-robin. The first requester at or after ptr, searching upward with wrap-around, wins. ptr resets to 0.
- Grant g is registered. It is frozen from SETUP through completion. New requests never preempt.
- Decode: evaluated on the granted address.
  - The lowest-index hitting slave wins if windows overlap.
  - Hit vector is registered on entry to SETUP.
- M_PSELx: the decoded one-hot during SETUP and ACCESS, else 0.
- M_PENABLE=1 only in ACCESS.
- M_PADDR, M_PWRITE, M_PWDATA carry the granted master's values in SETUP and ACCESS, and 0 in IDLE.
- In ACCESS:
  - S_PREADY[g] = M_PREADY.
  - S_PRDATA slot g = M_PRDATA.
  - All other slots are 0.
- Unmapped address: M_PSELx stays 0. Completion is generated locally in ACCESS (see Configuration).
- A master dropping S_PSELx mid-transfer is a protocol violation. The interconnect still completes the slave transfer and discards the result.

## Timing
- Reset: state IDLE, ptr 0, g 0, all outputs 0.
- Reset asserted mid-transfer aborts immediately. All M_* and S_* outputs drop to 0 asynchronously.
- Request seen in IDLE at cycle 0 gives SETUP at cycle 1 and ACCESS at cycle 2. With a zero-wait slave, S_PREADY[g]=1 at cycle 2.
- Minimum 3 cycles per transfer, plus slave wait states.
- Back-to-back: after completion the FSM is in IDLE for one cycle, then the next grant proceeds. Peak throughput is 1 transfer per 3 cycles.
- Simultaneous requests from all masters are served in strict rotation. Worst-case wait is (MASTER_PORTS-1) transfers.
- S_PREADY and S_PRDATA are combinational from M_PREADY and M_PRDATA. No registered return path.

## Configuration
- APB_INTERCON_PSLVERR_EN defined:
  - An unmapped access completes in ACCESS with S_PREADY[g]=1, S_PSLVERR[g]=1 and S_PRDATA slot g=0.
  - A mapped access drives S_PSLVERR[g]=0.
- APB_INTERCON_PSLVERR_EN undefined:
  - S_PSLVERR is tied to 0.
  - An unmapped access still completes after one ACCESS cycle with PRDATA 0. It is silently dropped.

## Structure
- Shared package vmicro16_apb_pkg holds:
  - the FSM state encoding (IDLE/SETUP/ACCESS);
  - the default SoC base/mask tables, matching the existing map: REGS 0x80/0xFFF0, GPIO0 0xA0/0xFFFF, GPIO1 0xA1/0xFFFF, GPIO2 0xA2/0xFFFF, UART0 0xB0/0xFFFE, BRAM0 0xC0/0xFFC0;
  - the slave-index constants.
- One sub-module, apb_rr_arbiter: a combinational round-robin pick from a request vector and ptr, outputting grant index and valid.

## Test plan
- Single master 0, read 0x0085, REGS slave with zero wait states, returning 0x1234 → M_PSELx has only the REGS bit high at cycles 1-2; M_PENABLE high at cycle 2; S_PREADY[0]=1 and S_PRDATA[15:0]=0x1234 at cycle 2.
- Masters 0-3 all request at once, ptr=0 → grant order 0,1,2,3. Master 0 requests again after its transfer → served after 3, not before 1.
- Slave holds M_PREADY low for 4 ACCESS cycles → FSM stays in ACCESS. Master 2 arriving meanwhile is not granted until completion.
- Write to 0x0050 (unmapped) with the macro defined → M_PSELx=0; S_PREADY[g]=1 and S_PSLVERR[g]=1 at cycle 2. With the macro undefined → same completion, S_PSLVERR=0.
- Overlapping windows (slave 1 and slave 3 both hit 0xC4) → only M_PSELx[1] is asserted.
- Reset pulled low during ACCESS → all outputs 0 asynchronously. After release, the FSM is in IDLE, ptr=0, and the first new request completes in 3 cycles.
